// File: rtl/kf6845_pkg.sv
// Shared definitions for the kf6845 refresh-address / cursor stage.
// Holds the blink-mode encoding, register indices and the default address width.
package kf6845_pkg;

  localparam int MA_WIDTH_DEFAULT = 14;

  typedef enum logic [1:0] {
    BLINK_STEADY = 2'b00,
    BLINK_OFF    = 2'b01,
    BLINK_16     = 2'b10,
    BLINK_32     = 2'b11
  } blink_mode_t;

  localparam logic [3:0] R10_CURSOR_START = 4'd10;
  localparam logic [3:0] R11_CURSOR_END   = 4'd11;
  localparam logic [3:0] R12_START_H      = 4'd12;
  localparam logic [3:0] R13_START_L      = 4'd13;
  localparam logic [3:0] R14_CURSOR_H     = 4'd14;
  localparam logic [3:0] R15_CURSOR_L     = 4'd15;

endpackage

// File: rtl/kf6845_skew_delay.sv
// Enabled shift register of DEPTH stages (1..3); realigns DISPEN/CURSOR with
// downstream character pipelines.
module kf6845_skew_delay #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic data_in,
  output logic data_out
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stages[0] <= 1'b0;
    end else if (enable) begin
      stages[0] <= data_in;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stages[gi] <= 1'b0;
      end else if (enable) begin
        stages[gi] <= stages[gi-1];
      end
    end
  end

  assign data_out = stages[DEPTH-1];

endmodule

// File: rtl/kf6845_address_cursor.sv
// Refresh memory address generator with cursor compare, blink gating and
// skew-adjustable DISPEN/CURSOR outputs.
module kf6845_address_cursor
  import kf6845_pkg::*;
#(
  parameter int MA_WIDTH    = MA_WIDTH_DEFAULT,
  parameter int DISPEN_SKEW = 0,
  parameter int CURSOR_SKEW = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                video_clock_enable,
  input  logic [7:0]          internal_data_bus,
  input  logic                write_cursor_start_register,
  input  logic                write_cursor_end_register,
  input  logic                write_start_address_h_register,
  input  logic                write_start_address_l_register,
  input  logic                write_cursor_h_register,
  input  logic                write_cursor_l_register,
  input  logic [7:0]          horizontal_displayed,
  input  logic                Horizontal,
  input  logic                H_Display,
  input  logic                V_Display,
  input  logic                V_Total,
  input  logic                Scanline_End,
  input  logic [4:0]          RA,
  output logic [MA_WIDTH-1:0] MA,
  output logic                DISPEN,
  output logic                CURSOR,
  output logic [MA_WIDTH-1:0] cursor_address
);

  localparam int HI_WIDTH = MA_WIDTH - 8;

  blink_mode_t          blink_mode;
  logic [4:0]           cursor_start;
  logic [4:0]           cursor_end;
  logic [HI_WIDTH-1:0]  start_high;
  logic [7:0]           start_low;
  logic [HI_WIDTH-1:0]  cursor_high;
  logic [7:0]           cursor_low;
  logic [4:0]           field_counter;
  logic [MA_WIDTH-1:0]  refresh_address;
  logic [MA_WIDTH-1:0]  row_start;
  logic [MA_WIDTH-1:0]  start_address;
  logic [MA_WIDTH-1:0]  next_row_start;
  logic                 blink_on;
  logic                 raster_hit;
  logic                 dispen_raw;
  logic                 cursor_raw;

  assign start_address  = {start_high, start_low};
  assign cursor_address = {cursor_high, cursor_low};
  assign next_row_start = row_start + MA_WIDTH'(horizontal_displayed);

  // CPU register writes ignore the character-clock strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_mode   <= BLINK_STEADY;
      cursor_start <= '0;
      cursor_end   <= '0;
      start_high   <= '0;
      start_low    <= '0;
      cursor_high  <= '0;
      cursor_low   <= '0;
    end else begin
      if (write_cursor_start_register) begin
        blink_mode   <= blink_mode_t'(internal_data_bus[6:5]);
        cursor_start <= internal_data_bus[4:0];
      end
      if (write_cursor_end_register)      cursor_end  <= internal_data_bus[4:0];
      if (write_start_address_h_register) start_high  <= internal_data_bus[HI_WIDTH-1:0];
      if (write_start_address_l_register) start_low   <= internal_data_bus;
      if (write_cursor_h_register)        cursor_high <= internal_data_bus[HI_WIDTH-1:0];
      if (write_cursor_l_register)        cursor_low  <= internal_data_bus;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_address <= '0;
      row_start       <= '0;
      field_counter   <= '0;
    end else if (video_clock_enable) begin
      if (V_Total) begin
        refresh_address <= start_address;
        row_start       <= start_address;
        field_counter   <= field_counter + 5'd1;
      end else if (Scanline_End) begin
        refresh_address <= next_row_start;
        row_start       <= next_row_start;
      end else if (Horizontal) begin
        refresh_address <= row_start;
      end else if (H_Display) begin
        refresh_address <= refresh_address + 1'b1;
      end
    end
  end

  assign MA = refresh_address;

  always_comb begin
    blink_on = 1'b1;
    unique case (blink_mode)
      BLINK_STEADY: blink_on = 1'b1;
      BLINK_OFF:    blink_on = 1'b0;
      BLINK_16:     blink_on = ~field_counter[3];
      BLINK_32:     blink_on = ~field_counter[4];
    endcase
  end

  // An inverted window (start > end) can never satisfy both bounds.
  assign raster_hit = (RA >= cursor_start) && (RA <= cursor_end);
  assign dispen_raw = H_Display & V_Display;
  assign cursor_raw = dispen_raw & (refresh_address == cursor_address) & raster_hit & blink_on;

  kf6845_skew_delay #(.DEPTH(1 + DISPEN_SKEW)) dispen_delay (
    .clock    (clock),
    .reset    (reset),
    .enable   (video_clock_enable),
    .data_in  (dispen_raw),
    .data_out (DISPEN)
  );

  kf6845_skew_delay #(.DEPTH(1 + CURSOR_SKEW)) cursor_delay (
    .clock    (clock),
    .reset    (reset),
    .enable   (video_clock_enable),
    .data_in  (cursor_raw),
    .data_out (CURSOR)
  );

endmodule

// File: tb/tb_kf6845_address_cursor.sv
// Randomized bench for kf6845_address_cursor: a character-timing generator drives
// two instances (no skew, and skewed) checked against an arithmetic frame model.
module tb_kf6845_address_cursor;

  localparam int W    = 14;
  localparam int MASK = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         video_clock_enable;
  logic [7:0]   internal_data_bus;
  logic         write_cursor_start_register, write_cursor_end_register;
  logic         write_start_address_h_register, write_start_address_l_register;
  logic         write_cursor_h_register, write_cursor_l_register;
  logic [7:0]   horizontal_displayed;
  logic         Horizontal, H_Display, V_Display, V_Total, Scanline_End;
  logic [4:0]   RA;
  logic [W-1:0] ma_a, ma_b, cur_addr_a, cur_addr_b;
  logic         dispen_a, dispen_b, cursor_a, cursor_b;

  always #5 clock = ~clock;

  kf6845_address_cursor dut_a (
    .clock(clock), .reset(reset), .video_clock_enable(video_clock_enable),
    .internal_data_bus(internal_data_bus),
    .write_cursor_start_register(write_cursor_start_register),
    .write_cursor_end_register(write_cursor_end_register),
    .write_start_address_h_register(write_start_address_h_register),
    .write_start_address_l_register(write_start_address_l_register),
    .write_cursor_h_register(write_cursor_h_register),
    .write_cursor_l_register(write_cursor_l_register),
    .horizontal_displayed(horizontal_displayed), .Horizontal(Horizontal),
    .H_Display(H_Display), .V_Display(V_Display), .V_Total(V_Total),
    .Scanline_End(Scanline_End), .RA(RA), .MA(ma_a), .DISPEN(dispen_a),
    .CURSOR(cursor_a), .cursor_address(cur_addr_a)
  );

  kf6845_address_cursor #(.DISPEN_SKEW(2), .CURSOR_SKEW(1)) dut_b (
    .clock(clock), .reset(reset), .video_clock_enable(video_clock_enable),
    .internal_data_bus(internal_data_bus),
    .write_cursor_start_register(write_cursor_start_register),
    .write_cursor_end_register(write_cursor_end_register),
    .write_start_address_h_register(write_start_address_h_register),
    .write_start_address_l_register(write_start_address_l_register),
    .write_cursor_h_register(write_cursor_h_register),
    .write_cursor_l_register(write_cursor_l_register),
    .horizontal_displayed(horizontal_displayed), .Horizontal(Horizontal),
    .H_Display(H_Display), .V_Display(V_Display), .V_Total(V_Total),
    .Scanline_End(Scanline_End), .RA(RA), .MA(ma_b), .DISPEN(dispen_b),
    .CURSOR(cursor_b), .cursor_address(cur_addr_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: frame position as row base plus column count.
  int m_row_base, m_col, m_start, m_cur, m_cs, m_ce, m_blink, m_field;
  bit dhist[3];
  bit chist[3];

  // Character timing generator.
  int g_hd, g_htot, g_nscan, g_nrows, g_ndisp;
  int g_ch, g_scan, g_row;

  int hits_a, hits_b, probe_expect;
  bit frame_done;

  function automatic int m_ma();
    return (m_row_base + m_col) & MASK;
  endfunction

  task automatic model_reset();
    m_row_base = 0; m_col = 0; m_start = 0; m_cur = 0;
    m_cs = 0; m_ce = 0; m_blink = 0; m_field = 0;
    for (int i = 0; i < 3; i++) begin dhist[i] = 0; chist[i] = 0; end
  endtask

  task automatic set_timing(input int hd, input int htot, input int nscan, input int nrows, input int ndisp);
    g_hd = hd; g_htot = htot; g_nscan = nscan; g_nrows = nrows; g_ndisp = ndisp;
    g_ch = htot - 1; g_scan = nscan - 1; g_row = nrows - 1;
  endtask

  task automatic run_cycle(input bit en, input int wsel, input int wdata);
    bit hd_now, hz, sl, vt, vd, raw_d, raw_c, blink_on, probe_now;
    int ra;
    hd_now = g_ch < g_hd;
    hz     = g_ch == g_htot - 1;
    vd     = g_row < g_ndisp;
    ra     = g_scan;
    sl     = en && hz && (g_scan == g_nscan - 1);
    vt     = sl && (g_row == g_nrows - 1);
    probe_now = 0;

    video_clock_enable = en;
    horizontal_displayed = 8'(g_hd);
    H_Display = hd_now; Horizontal = hz; V_Display = vd; RA = 5'(ra);
    Scanline_End = sl; V_Total = vt;
    internal_data_bus = 8'(wdata);
    write_cursor_start_register    = (wsel == 10);
    write_cursor_end_register      = (wsel == 11);
    write_start_address_h_register = (wsel == 12);
    write_start_address_l_register = (wsel == 13);
    write_cursor_h_register        = (wsel == 14);
    write_cursor_l_register        = (wsel == 15);

    if (en) begin
      case (m_blink)
        0:       blink_on = 1;
        1:       blink_on = 0;
        2:       blink_on = (m_field % 16) < 8;
        default: blink_on = m_field < 16;
      endcase
      raw_d = hd_now && vd;
      raw_c = raw_d && (m_ma() == m_cur) && (ra >= m_cs) && (ra <= m_ce) && blink_on;
      dhist[2] = dhist[1]; dhist[1] = dhist[0]; dhist[0] = raw_d;
      chist[2] = chist[1]; chist[1] = chist[0]; chist[0] = raw_c;
      if (vt) begin
        m_row_base = m_start; m_col = 0; m_field = (m_field + 1) % 32;
      end else if (sl) begin
        m_row_base = (m_row_base + g_hd) & MASK; m_col = 0;
        probe_now = (g_row == 0);
      end else if (hz) m_col = 0;
      else if (hd_now) m_col++;
      if (hz) begin
        g_ch = 0;
        if (sl) begin g_scan = 0; g_row = vt ? 0 : g_row + 1; end
        else g_scan++;
      end else g_ch++;
    end
    case (wsel)
      10: begin m_cs = wdata & 31; m_blink = (wdata >> 5) & 3; end
      11: m_ce = wdata & 31;
      12: m_start = ((wdata & 63) << 8) | (m_start & 255);
      13: m_start = (m_start & 16'h3F00) | (wdata & 255);
      14: m_cur = ((wdata & 63) << 8) | (m_cur & 255);
      15: m_cur = (m_cur & 16'h3F00) | (wdata & 255);
      default: ;
    endcase

    @(posedge clock);
    @(negedge clock);
    check_value("MA", 32'(ma_a), 32'(m_ma()));
    check_value("MA_skewed", 32'(ma_b), 32'(m_ma()));
    check_value("DISPEN", 32'(dispen_a), 32'(dhist[0]));
    check_value("CURSOR", 32'(cursor_a), 32'(chist[0]));
    check_value("DISPEN_skew2", 32'(dispen_b), 32'(dhist[2]));
    check_value("CURSOR_skew1", 32'(cursor_b), 32'(chist[1]));
    check_value("cursor_address", 32'(cur_addr_a), 32'(m_cur));
    if (probe_now && probe_expect >= 0) check_value("second_row_start", 32'(ma_a), 32'(probe_expect));
    if (en) begin
      hits_a += int'(cursor_a);
      hits_b += int'(cursor_b);
    end
    if (vt) frame_done = 1;
  endtask

  task automatic write_reg(input int wsel, input int wdata);
    run_cycle(0, wsel, wdata);
  endtask

  task automatic run_frame(input int en_pct, input bit rand_wr);
    int wsel, wdata, off;
    hits_a = 0; hits_b = 0; frame_done = 0;
    for (int n = 0; n < 20000 && !frame_done; n++) begin
      wsel = 0; wdata = 0;
      if (rand_wr && $urandom_range(63) == 0) begin
        wsel  = $urandom_range(15, 10);
        wdata = $urandom_range(255);
        if (wsel >= 14 && $urandom_range(1) == 1) begin
          off   = (m_start + $urandom_range(g_hd)) & MASK;
          wdata = (wsel == 14) ? (off >> 8) : (off & 255);
        end
      end
      run_cycle($urandom_range(99) < en_pct, wsel, wdata);
    end
    if (!frame_done) check_value("frame_timeout", 0, 1);
    $display("frame hd=%0d rows=%0d scans=%0d start=0x%04h cursor=0x%04h hits=%0d/%0d field=%0d",
             g_hd, g_nrows, g_nscan, m_start, m_cur, hits_a, hits_b, m_field);
  endtask

  task automatic set_addr(input int start, input int cur);
    write_reg(12, start >> 8); write_reg(13, start & 255);
    write_reg(14, cur >> 8);   write_reg(15, cur & 255);
  endtask

  int visible;

  initial begin
    reset = 1;
    video_clock_enable = 0; internal_data_bus = 0;
    write_cursor_start_register = 0; write_cursor_end_register = 0;
    write_start_address_h_register = 0; write_start_address_l_register = 0;
    write_cursor_h_register = 0; write_cursor_l_register = 0;
    horizontal_displayed = 0; Horizontal = 0; H_Display = 0; V_Display = 0;
    V_Total = 0; Scanline_End = 0; RA = 0;
    probe_expect = -1;
    model_reset();
    set_timing(40, 44, 8, 3, 3);
    repeat (3) @(negedge clock);
    check_value("reset_MA", 32'(ma_a), 0);
    check_value("reset_DISPEN", 32'(dispen_a), 0);
    check_value("reset_CURSOR", 32'(cursor_a), 0);
    check_value("reset_cursor_address", 32'(cur_addr_a), 0);
    reset = 0;

    // Row sequencing from 0x0100, 40 characters, 8 scanlines per row.
    set_addr(16'h0100, 16'h3FFF);
    write_reg(10, 8'h00); write_reg(11, 8'h1F);
    probe_expect = 16'h0128;
    set_timing(40, 44, 8, 3, 3);
    run_frame(100, 0);
    repeat (2) run_frame(60, 0);

    // Address wrap through 0x3FFF.
    set_addr(16'h3FF0, 16'h3FFF);
    probe_expect = 16'h0010;
    set_timing(32, 36, 4, 3, 3);
    run_frame(100, 0);
    repeat (2) run_frame(70, 0);
    probe_expect = -1;

    // Cursor at 0x0105 on rasters 6..7.
    set_addr(16'h0100, 16'h0105);
    write_reg(10, 8'h06); write_reg(11, 8'h07);
    set_timing(40, 44, 8, 3, 3);
    run_frame(100, 0);
    for (int f = 0; f < 2; f++) begin
      run_frame(65, 0);
      check_value("cursor_hits", hits_a, 2);
      check_value("cursor_hits_skewed", hits_b, 2);
    end

    // Blink modes over 64 fields each.
    set_addr(16'h0100, 16'h0103);
    write_reg(11, 8'h01);
    set_timing(8, 10, 2, 2, 2);
    for (int k = 0; k < 3; k++) begin
      int mode;
      mode = (k == 0) ? 2 : (k == 1) ? 1 : 3;
      write_reg(10, mode << 5);
      run_frame(100, 0);
      visible = 0;
      for (int f = 0; f < 64; f++) begin
        run_frame(80, 0);
        if (hits_a > 0) visible++;
      end
      check_value($sformatf("blink_mode%0d_visible", mode), visible, (mode == 1) ? 0 : 32);
    end

    // Inverted raster window: start 9 above end 3.
    write_reg(10, 8'h09); write_reg(11, 8'h03);
    set_timing(8, 10, 12, 2, 2);
    run_frame(100, 0);
    run_frame(70, 0);
    check_value("inverted_window_hits", hits_a, 0);
    check_value("inverted_window_hits_skewed", hits_b, 0);

    // Randomized timing, enables and register traffic.
    for (int f = 0; f < 30; f++) begin
      int hd, nrows;
      hd = $urandom_range(24, 4);
      nrows = $urandom_range(3, 1);
      set_timing(hd, hd + $urandom_range(6, 2), $urandom_range(4, 1), nrows, $urandom_range(nrows, 1));
      if (f % 10 == 0) begin
        set_addr($urandom_range(MASK), 0);
        write_reg(14, ((m_start + 2) & MASK) >> 8);
        write_reg(15, (m_start + 2) & 255);
        write_reg(10, $urandom_range(127));
        write_reg(11, 8'h1F);
      end
      run_frame($urandom_range(100, 40), 1);
    end

    // Asynchronous reset mid-line, then wait for the first V_Total.
    set_addr(16'h0100, 16'h0123);
    write_reg(10, 8'h00); write_reg(11, 8'h1F);
    set_timing(40, 44, 8, 3, 3);
    run_frame(100, 0);
    for (int n = 0; n < 35; n++) run_cycle(1, 0, 0);
    check_value("pre_reset_MA", 32'(ma_a), 16'h0123);
    #2 reset = 1;
    #1;
    check_value("async_reset_MA", 32'(ma_a), 0);
    check_value("async_reset_DISPEN", 32'(dispen_a), 0);
    check_value("async_reset_CURSOR", 32'(cursor_a), 0);
    check_value("async_reset_MA_skewed", 32'(ma_b), 0);
    check_value("async_reset_DISPEN_skewed", 32'(dispen_b), 0);
    model_reset();
    @(negedge clock);
    reset = 0;
    g_ch = g_hd;
    for (int n = 0; n < 4; n++) run_cycle(1, 0, 0);
    set_addr(16'h0200, 16'h0203);
    write_reg(10, 8'h40); write_reg(11, 8'h1F);
    check_value("hold_before_vtotal", 32'(ma_a), 0);
    set_timing(8, 10, 2, 2, 2);
    run_frame(100, 0);
    check_value("load_after_vtotal", 32'(ma_a), 16'h0200);
    visible = 0;
    for (int f = 0; f < 7; f++) begin
      run_frame(80, 0);
      if (hits_a > 0) visible++;
    end
    check_value("fields_1_to_7_visible", visible, 7);
    run_frame(80, 0);
    check_value("field_8_hidden", hits_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
